// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the hazard/forwarding controller:
//   - state_e      : controller FSM states (RUN / LDSTALL / REDIR)
//   - WD_*         : write-back source select encodings used by the pipeline
//   - HOLD_W       : width of the redirect hold counter
//   - src_match()  : "does this pipeline stage produce the register being read"
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_REDIR   = 2'd2
  } state_e;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_IMM  = 2'd3;

  localparam int HOLD_W = 8;

  // x0 is hard-wired to zero, so a write to it is never a forwarding source.
  function automatic logic src_match(input logic [4:0] rs, input logic re,
                                     input logic we, input logic [4:0] wr);
    return re && we && (wr != 5'd0) && (wr == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard controller.
//   master : the pipeline (drives ID/EX/MEM/WB info, receives controls)
//   slave  : the hazard controller
//   Inputs to the controller : id_rs1/2, id_rs1/2_re, id_rD1/2, ex_*, mem_*, wb_*
//   Outputs of the controller: pc_stall, if_id_stall, if_id_flush, id_ex_flush,
//                              rD1_op/rD2_op, rD1_f/rD2_f, stall_cnt, flush_cnt, state_o
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_re;
  logic             id_rs2_re;
  logic [31:0]      id_rD1;
  logic [31:0]      id_rD2;
  logic [4:0]       ex_wR;
  logic             ex_rf_we;
  logic [1:0]       ex_wd_sel;
  logic [31:0]      ex_wd;
  logic             ex_redirect;
  logic [4:0]       mem_wR;
  logic             mem_rf_we;
  logic [31:0]      mem_wd;
  logic [4:0]       wb_wR;
  logic             wb_rf_we;
  logic [31:0]      wb_wd;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             rD1_op;
  logic             rD2_op;
  logic [31:0]      rD1_f;
  logic [31:0]      rD2_f;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state_o;

  modport master (
    output id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_rD1, id_rD2,
           ex_wR, ex_rf_we, ex_wd_sel, ex_wd, ex_redirect,
           mem_wR, mem_rf_we, mem_wd, wb_wR, wb_rf_we, wb_wd,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
           rD1_op, rD2_op, rD1_f, rD2_f, stall_cnt, flush_cnt, state_o
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_rD1, id_rD2,
           ex_wR, ex_rf_we, ex_wd_sel, ex_wd, ex_redirect,
           mem_wR, mem_rf_we, mem_wd, wb_wR, wb_rf_we, wb_wd,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
           rD1_op, rD2_op, rD1_f, rD2_f, stall_cnt, flush_cnt, state_o
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel
//   Forwarding source selector for one ID operand.
//   Inputs : rs/re of the operand, and (wR, rf_we, data) of EX, MEM and WB
//            (plus EX wd_sel to recognise loads).
//   Outputs: hit         - a forwardable producer was found, data is valid
//            is_load_hit - the youngest producer is a load still in EX
//            data        - forwarded value (0 when hit=0)
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0]  rs,
  input  logic        re,
  input  logic [4:0]  ex_wr,
  input  logic        ex_rf_we,
  input  logic [1:0]  ex_wd_sel,
  input  logic [31:0] ex_wd,
  input  logic [4:0]  mem_wr,
  input  logic        mem_rf_we,
  input  logic [31:0] mem_wd,
  input  logic [4:0]  wb_wr,
  input  logic        wb_rf_we,
  input  logic [31:0] wb_wd,
  output logic        hit,
  output logic        is_load_hit,
  output logic [31:0] data
);

  // The youngest producer wins. A load in EX shadows the older MEM/WB
  // values: those would be stale, so the operand is left unforwarded and
  // the load-use stall takes care of it.
  always_comb begin
    hit         = 1'b0;
    is_load_hit = 1'b0;
    data        = 32'd0;
    if (src_match(rs, re, ex_rf_we, ex_wr)) begin
      if (ex_wd_sel == WD_DRAM) begin
        is_load_hit = 1'b1;
      end else begin
        hit  = 1'b1;
        data = ex_wd;
      end
    end else if (src_match(rs, re, mem_rf_we, mem_wr)) begin
      hit  = 1'b1;
      data = mem_wd;
    end else if (src_match(rs, re, wb_rf_we, wb_wr)) begin
      hit  = 1'b1;
      data = wb_wd;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for the 5-stage pipeline.
//   Ports:
//     clk  - clock, all state on posedge
//     rst  - synchronous active-high reset
//     bus  - hazard_ctrl_if.slave: ID/EX/MEM/WB information in; PC/IF-ID/ID-EX
//            stall/flush controls, forwarded operands and selects, event
//            counters and FSM state out.
//   Parameters:
//     REDIR_HOLD - extra flush cycles after a redirect (fetch latency)
//     CNT_W      - width of the wrapping stall/flush event counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REDIR_HOLD = 1,
  parameter int CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  logic              hit1, hit2, ld1, ld2, ld_use;
  logic [31:0]       data1, data2;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic              rd1_op, rd2_op;
  logic [31:0]       rd1_f, rd2_f;

  // Register-file read data is carried for tracing only.
  logic unused_trace;
  assign unused_trace = ^{bus.id_rD1, bus.id_rD2};

  hazard_ctrl_fwd_sel u_fwd_rs1 (
    .rs(bus.id_rs1), .re(bus.id_rs1_re),
    .ex_wr(bus.ex_wR), .ex_rf_we(bus.ex_rf_we), .ex_wd_sel(bus.ex_wd_sel), .ex_wd(bus.ex_wd),
    .mem_wr(bus.mem_wR), .mem_rf_we(bus.mem_rf_we), .mem_wd(bus.mem_wd),
    .wb_wr(bus.wb_wR), .wb_rf_we(bus.wb_rf_we), .wb_wd(bus.wb_wd),
    .hit(hit1), .is_load_hit(ld1), .data(data1)
  );

  hazard_ctrl_fwd_sel u_fwd_rs2 (
    .rs(bus.id_rs2), .re(bus.id_rs2_re),
    .ex_wr(bus.ex_wR), .ex_rf_we(bus.ex_rf_we), .ex_wd_sel(bus.ex_wd_sel), .ex_wd(bus.ex_wd),
    .mem_wr(bus.mem_wR), .mem_rf_we(bus.mem_rf_we), .mem_wd(bus.mem_wd),
    .wb_wr(bus.wb_wR), .wb_rf_we(bus.wb_rf_we), .wb_wd(bus.wb_wd),
    .hit(hit2), .is_load_hit(ld2), .data(data2)
  );

  assign ld_use = ld1 | ld2;

  // State register and event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      hold_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and control outputs. Everything combinational is held at 0
  // while rst is high. A redirect always beats a load-use stall: the
  // instruction that would have stalled is being flushed anyway.
  // LDSTALL handles a stray redirect exactly like RUN, but never stalls
  // because EX holds the bubble inserted by the previous cycle.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    rd1_op      = 1'b0;
    rd2_op      = 1'b0;
    rd1_f       = 32'd0;
    rd2_f       = 32'd0;
    if (!rst) begin
      rd1_op = hit1;
      rd2_op = hit2;
      rd1_f  = data1;
      rd2_f  = data2;
      case (state_q)
        ST_RUN, ST_LDSTALL: begin
          if (bus.ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
            hold_d      = HOLD_W'(REDIR_HOLD);
            state_d     = (REDIR_HOLD > 0) ? ST_REDIR : ST_RUN;
          end else if (state_q == ST_RUN && ld_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
            state_d     = ST_LDSTALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_REDIR: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (bus.ex_redirect) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
            hold_d      = HOLD_W'(REDIR_HOLD);
            state_d     = (REDIR_HOLD > 0) ? ST_REDIR : ST_RUN;
          end else if (hold_q <= HOLD_W'(1)) begin
            hold_d  = '0;
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: begin
          hold_d  = '0;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.if_id_stall = if_id_stall;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.rD1_op      = rd1_op;
  assign bus.rD2_op      = rd2_op;
  assign bus.rD1_f       = rd1_f;
  assign bus.rD2_f       = rd2_f;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl: forwarding vector table, hand-written
//   stall/redirect/reset sequences and a randomized run, all compared against
//   a behavioural model of pending flush cycles and stall shadows.
module tb_hazard_ctrl;

  localparam int          REDIR_HOLD = 1;
  localparam logic [1:0]  LOAD_SEL   = 2'd1;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic        re1, re2;
    logic [4:0]  ex_wr;
    logic        ex_we;
    logic [1:0]  ex_sel;
    logic [31:0] ex_wd;
    logic        ex_redir;
    logic [4:0]  mem_wr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [4:0]  wb_wr;
    logic        wb_we;
    logic [31:0] wb_wd;
  } stim_t;

  typedef struct {
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic        op1, op2;
    logic [31:0] f1, f2;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
  } obs_t;

  typedef struct {
    stim_t       s;
    logic        op1;
    logic [31:0] f1;
    logic        op2;
    logic [31:0] f2;
    logic        stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) bus ();

  hazard_ctrl #(.REDIR_HOLD(REDIR_HOLD), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  obs_t got;
  obs_t expd;

  // Model state: flush cycles still owed after the current one, whether the
  // previous cycle was a load-use stall, and the two event counts.
  int unsigned m_flush_left = 0;
  bit          m_shadow     = 1'b0;
  bit          m_stalling   = 1'b0;
  logic [31:0] m_stall_cnt  = 32'd0;
  logic [31:0] m_flush_cnt  = 32'd0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rs1: 5'd0, rs2: 5'd0, re1: 1'b0, re2: 1'b0,
          ex_wr: 5'd0, ex_we: 1'b0, ex_sel: 2'd0, ex_wd: 32'd0, ex_redir: 1'b0,
          mem_wr: 5'd0, mem_we: 1'b0, mem_wd: 32'd0,
          wb_wr: 5'd0, wb_we: 1'b0, wb_wd: 32'd0};
    return s;
  endfunction

  function automatic stim_t mkFwd(input logic [4:0] rs1, input logic re1,
                                  input logic [4:0] rs2, input logic re2,
                                  input logic [4:0] exw, input logic exe, input logic [1:0] exs,
                                  input logic [31:0] exd,
                                  input logic [4:0] mw, input logic me, input logic [31:0] md,
                                  input logic [4:0] ww, input logic we, input logic [31:0] wd);
    stim_t s;
    s = idle();
    s.rs1 = rs1; s.re1 = re1; s.rs2 = rs2; s.re2 = re2;
    s.ex_wr = exw; s.ex_we = exe; s.ex_sel = exs; s.ex_wd = exd;
    s.mem_wr = mw; s.mem_we = me; s.mem_wd = md;
    s.wb_wr = ww; s.wb_we = we; s.wb_wd = wd;
    return s;
  endfunction

  // Search the producing stages youngest-first; a load in EX is a hazard,
  // not a source.
  task automatic fwdModel(input stim_t s, input bit second, output logic op,
                          output logic [31:0] f, output logic ld);
    logic [4:0]  wr[3];
    logic        we[3];
    logic [31:0] wd[3];
    logic [4:0]  rs;
    logic        re;
    bit          found;
    wr = '{s.ex_wr, s.mem_wr, s.wb_wr};
    we = '{s.ex_we, s.mem_we, s.wb_we};
    wd = '{s.ex_wd, s.mem_wd, s.wb_wd};
    rs = second ? s.rs2 : s.rs1;
    re = second ? s.re2 : s.re1;
    op = 1'b0; f = 32'd0; ld = 1'b0; found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && re && rs != 5'd0 && we[i] && wr[i] == rs) begin
        found = 1'b1;
        if (i == 0 && s.ex_sel == LOAD_SEL) ld = 1'b1;
        else begin op = 1'b1; f = wd[i]; end
      end
    end
  endtask

  task automatic modelComb(input stim_t s, output obs_t e);
    logic ld1, ld2;
    bit   flushing;
    e.state     = (m_flush_left > 0) ? 2'd2 : (m_shadow ? 2'd1 : 2'd0);
    e.stall_cnt = m_stall_cnt;
    e.flush_cnt = m_flush_cnt;
    e.pc_stall = 1'b0; e.if_id_stall = 1'b0; e.if_id_flush = 1'b0; e.id_ex_flush = 1'b0;
    e.op1 = 1'b0; e.op2 = 1'b0; e.f1 = 32'd0; e.f2 = 32'd0;
    m_stalling = 1'b0;
    if (!s.rst) begin
      fwdModel(s, 1'b0, e.op1, e.f1, ld1);
      fwdModel(s, 1'b1, e.op2, e.f2, ld2);
      flushing      = (m_flush_left > 0) || s.ex_redir;
      m_stalling    = !flushing && !m_shadow && (ld1 || ld2);
      e.pc_stall    = m_stalling;
      e.if_id_stall = m_stalling;
      e.if_id_flush = flushing;
      e.id_ex_flush = flushing || m_stalling;
    end
  endtask

  task automatic modelUpdate(input stim_t s);
    if (s.rst) begin
      m_flush_left = 0; m_shadow = 1'b0; m_stall_cnt = 32'd0; m_flush_cnt = 32'd0;
    end else begin
      if (s.ex_redir) begin
        m_flush_cnt  = m_flush_cnt + 32'd1;
        m_flush_left = REDIR_HOLD;
      end else if (m_flush_left > 0) begin
        m_flush_left = m_flush_left - 1;
      end
      m_shadow = m_stalling;
      if (m_stalling) m_stall_cnt = m_stall_cnt + 32'd1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst             = s.rst;
    bus.id_rs1      = s.rs1;    bus.id_rs2    = s.rs2;
    bus.id_rs1_re   = s.re1;    bus.id_rs2_re = s.re2;
    bus.id_rD1      = 32'hDEAD_0001;
    bus.id_rD2      = 32'hDEAD_0002;
    bus.ex_wR       = s.ex_wr;  bus.ex_rf_we  = s.ex_we;
    bus.ex_wd_sel   = s.ex_sel; bus.ex_wd     = s.ex_wd;
    bus.ex_redirect = s.ex_redir;
    bus.mem_wR      = s.mem_wr; bus.mem_rf_we = s.mem_we; bus.mem_wd = s.mem_wd;
    bus.wb_wR       = s.wb_wr;  bus.wb_rf_we  = s.wb_we;  bus.wb_wd  = s.wb_wd;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input obs_t a, input obs_t e);
    checkVal({tag, ".pc_stall"},    32'(a.pc_stall),    32'(e.pc_stall));
    checkVal({tag, ".if_id_stall"}, 32'(a.if_id_stall), 32'(e.if_id_stall));
    checkVal({tag, ".if_id_flush"}, 32'(a.if_id_flush), 32'(e.if_id_flush));
    checkVal({tag, ".id_ex_flush"}, 32'(a.id_ex_flush), 32'(e.id_ex_flush));
    checkVal({tag, ".rD1_op"},      32'(a.op1),         32'(e.op1));
    checkVal({tag, ".rD2_op"},      32'(a.op2),         32'(e.op2));
    checkVal({tag, ".rD1_f"},       a.f1,               e.f1);
    checkVal({tag, ".rD2_f"},       a.f2,               e.f2);
    checkVal({tag, ".state_o"},     32'(a.state),       32'(e.state));
    checkVal({tag, ".stall_cnt"},   a.stall_cnt,        e.stall_cnt);
    checkVal({tag, ".flush_cnt"},   a.flush_cnt,        e.flush_cnt);
  endtask

  // One pipeline cycle: inputs driven 1 time unit after the edge, outputs
  // sampled mid-cycle, model advanced after the following edge.
  task automatic runCycle(input string tag, input stim_t s);
    applyStimulus(s);
    modelComb(s, expd);
    #3;
    got.pc_stall    = bus.pc_stall;    got.if_id_stall = bus.if_id_stall;
    got.if_id_flush = bus.if_id_flush; got.id_ex_flush = bus.id_ex_flush;
    got.op1 = bus.rD1_op; got.op2 = bus.rD2_op;
    got.f1  = bus.rD1_f;  got.f2  = bus.rD2_f;
    got.state     = bus.state_o;
    got.stall_cnt = bus.stall_cnt;
    got.flush_cnt = bus.flush_cnt;
    checkOutput(tag, got, expd);
    @(posedge clk);
    #1;
    modelUpdate(s);
  endtask

  task automatic doReset();
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    runCycle("reset", s);
    runCycle("post_reset", idle());
  endtask

  vec_t vecs[9];

  initial begin
    stim_t s;
    // forwarding table: {stim, rD1_op, rD1_f, rD2_op, rD2_f, pc_stall}
    vecs[0] = '{mkFwd(5, 1, 0, 0, 5, 1, 0, 32'h11, 0, 0, 0, 0, 0, 0), 1, 32'h11, 0, 0, 0};
    vecs[1] = '{mkFwd(5, 1, 0, 0, 5, 1, 0, 32'h11, 5, 1, 32'h22, 0, 0, 0), 1, 32'h11, 0, 0, 0};
    vecs[2] = '{mkFwd(0, 1, 0, 1, 0, 1, 0, 32'h55, 0, 1, 32'h66, 0, 1, 32'h77), 0, 0, 0, 0, 0};
    vecs[3] = '{mkFwd(0, 0, 7, 1, 3, 1, 2, 32'h99, 7, 1, 32'h22, 0, 0, 0), 0, 0, 1, 32'h22, 0};
    vecs[4] = '{mkFwd(9, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 9, 1, 32'h33), 1, 32'h33, 1, 32'h33, 0};
    vecs[5] = '{mkFwd(9, 1, 0, 0, 0, 0, 0, 0, 9, 1, 32'h44, 9, 1, 32'h33), 1, 32'h44, 0, 0, 0};
    vecs[6] = '{mkFwd(4, 0, 4, 0, 4, 1, 0, 32'h12, 4, 1, 32'h34, 0, 0, 0), 0, 0, 0, 0, 0};
    vecs[7] = '{mkFwd(8, 1, 0, 0, 8, 0, 0, 32'h12, 8, 1, 32'h56, 0, 0, 0), 1, 32'h56, 0, 0, 0};
    vecs[8] = '{mkFwd(0, 0, 6, 1, 6, 1, 1, 32'h77, 6, 1, 32'h88, 0, 0, 0), 0, 0, 0, 0, 1};

    applyStimulus('{rst: 1'b1, default: '0});
    repeat (2) @(posedge clk);
    #1;
    doReset();
    checkVal("reset.state_o", 32'(got.state), 32'd0);

    for (int i = 0; i < 9; i++) begin
      runCycle($sformatf("vec%0d", i), vecs[i].s);
      checkVal($sformatf("vec%0d.rD1_op", i),   32'(got.op1),      32'(vecs[i].op1));
      checkVal($sformatf("vec%0d.rD1_f", i),    got.f1,            vecs[i].f1);
      checkVal($sformatf("vec%0d.rD2_op", i),   32'(got.op2),      32'(vecs[i].op2));
      checkVal($sformatf("vec%0d.rD2_f", i),    got.f2,            vecs[i].f2);
      checkVal($sformatf("vec%0d.pc_stall", i), 32'(got.pc_stall), 32'(vecs[i].stall));
      runCycle("vec_gap", idle());
    end

    // load-use: one bubble, then the load value arrives from MEM
    doReset();
    runCycle("lduse0", mkFwd(0, 0, 6, 1, 6, 1, LOAD_SEL, 32'h0, 0, 0, 0, 0, 0, 0));
    checkVal("lduse0.if_id_stall", 32'(got.if_id_stall), 32'd1);
    checkVal("lduse0.id_ex_flush", 32'(got.id_ex_flush), 32'd1);
    runCycle("lduse1", mkFwd(0, 0, 6, 1, 0, 0, 0, 32'h0, 6, 1, 32'hABCD, 0, 0, 0));
    checkVal("lduse1.state_o",   32'(got.state),    32'd1);
    checkVal("lduse1.stall_cnt", got.stall_cnt,     32'd1);
    checkVal("lduse1.pc_stall",  32'(got.pc_stall), 32'd0);
    checkVal("lduse1.rD2_f",     got.f2,            32'hABCD);
    runCycle("lduse2", idle());
    checkVal("lduse2.state_o", 32'(got.state), 32'd0);

    // redirect pulse: two flush cycles, then back to RUN
    doReset();
    s = idle(); s.ex_redir = 1'b1;
    runCycle("redir0", s);
    checkVal("redir0.if_id_flush", 32'(got.if_id_flush), 32'd1);
    runCycle("redir1", idle());
    checkVal("redir1.id_ex_flush", 32'(got.id_ex_flush), 32'd1);
    checkVal("redir1.state_o",     32'(got.state),       32'd2);
    checkVal("redir1.flush_cnt",   got.flush_cnt,        32'd1);
    runCycle("redir2", idle());
    checkVal("redir2.if_id_flush", 32'(got.if_id_flush), 32'd0);
    checkVal("redir2.state_o",     32'(got.state),       32'd0);

    // redirect together with load-use: the redirect wins
    doReset();
    s = mkFwd(6, 1, 0, 0, 6, 1, LOAD_SEL, 32'h0, 0, 0, 0, 0, 0, 0);
    s.ex_redir = 1'b1;
    runCycle("both0", s);
    checkVal("both0.pc_stall",    32'(got.pc_stall),    32'd0);
    checkVal("both0.id_ex_flush", 32'(got.id_ex_flush), 32'd1);
    runCycle("both1", idle());
    checkVal("both1.state_o",   32'(got.state), 32'd2);
    checkVal("both1.stall_cnt", got.stall_cnt,  32'd0);

    // reset in the middle of a redirect
    doReset();
    s = idle(); s.ex_redir = 1'b1;
    runCycle("rstredir0", s);
    s = idle(); s.rst = 1'b1;
    runCycle("rstredir1", s);
    checkVal("rstredir1.if_id_flush", 32'(got.if_id_flush), 32'd0);
    runCycle("rstredir2", idle());
    checkVal("rstredir2.state_o",     32'(got.state),       32'd0);
    checkVal("rstredir2.id_ex_flush", 32'(got.id_ex_flush), 32'd0);
    checkVal("rstredir2.flush_cnt",   got.flush_cnt,        32'd0);

    // randomized traffic over a small register window to provoke hits
    doReset();
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst      = ($urandom_range(0, 49) == 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.re1      = 1'($urandom_range(0, 1));
      s.re2      = 1'($urandom_range(0, 1));
      s.ex_wr    = 5'($urandom_range(0, 3));
      s.ex_we    = 1'($urandom_range(0, 1));
      s.ex_sel   = 2'($urandom_range(0, 3));
      s.ex_wd    = $urandom;
      s.ex_redir = ($urandom_range(0, 7) == 0);
      s.mem_wr   = 5'($urandom_range(0, 3));
      s.mem_we   = 1'($urandom_range(0, 1));
      s.mem_wd   = $urandom;
      s.wb_wr    = 5'($urandom_range(0, 3));
      s.wb_we    = 1'($urandom_range(0, 1));
      s.wb_wd    = $urandom;
      runCycle("rand", s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
